// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder controller.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_WIDTH = 64;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, time-shared by the serial adder controller.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sout,
    output logic cout
);

    assign sout = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: operands shift LSB-first through a single full
// adder with a registered carry, wrapped in valid/ready handshakes.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_shifted;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             capture;
    logic             last_bit;

    full_adder u_full_adder (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sout (fa_sum),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    assign sum_shifted = (sum_sh >> 1) | ({{(WIDTH-1){1'b0}}, fa_sum} << (WIDTH-1));
    assign last_bit    = (cnt == CNT_W'(WIDTH-1));
    assign capture     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    next_state = in_valid ? RUN : IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (capture) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= cin;
            sum_sh <= '0;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_shifted;
            carry  <= fa_cout;
            // The carry register still holds the carry into the MSB on the last bit.
            if (last_bit) begin
                sum  <= sum_shifted;
                cout <= fa_cout;
                ovf  <= carry ^ fa_cout;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    int checks = 0;
    int errors = 0;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    // Called just after the capture edge; counts edges until out_valid, bounded.
    task automatic waitResult(input string tag, output int cycles, output int busyCycles);
        cycles = 0;
        busyCycles = 0;
        while (!out_valid && cycles < 40) begin
            if (busy) busyCycles++;
            nextCycle();
            cycles++;
        end
        checkOutput({tag, "_timeout"}, 64'(out_valid), 64'd1);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_in_ready"},  64'(in_ready),  64'd1);
        checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_busy"},      64'(busy),      64'd0);
        checkOutput({tag, "_sum"},       64'(sum),       64'd0);
        checkOutput({tag, "_cout"},      64'(cout),      64'd0);
        checkOutput({tag, "_ovf"},       64'(ovf),       64'd0);
    endtask

    task automatic checkResult(input string tag, input logic [7:0] expSum,
                               input logic expCout, input logic expOvf);
        checkOutput({tag, "_sum"},  64'(sum),  64'(expSum));
        checkOutput({tag, "_cout"}, 64'(cout), 64'(expCout));
        checkOutput({tag, "_ovf"},  64'(ovf),  64'(expOvf));
    endtask

    task automatic applyStimulus(input string tag, input logic [7:0] opA, input logic [7:0] opB,
                                 input logic opCin, input logic [7:0] expSum,
                                 input logic expCout, input logic expOvf);
        int cycles;
        int busyCycles;
        a = opA;
        b = opB;
        cin = opCin;
        in_valid = 1'b1;
        out_ready = 1'b0;
        #1;
        checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        nextCycle();
        in_valid = 1'b0;
        waitResult(tag, cycles, busyCycles);
        checkOutput({tag, "_latency"}, 64'(cycles), 64'd8);
        checkOutput({tag, "_busy_cycles"}, 64'(busyCycles), 64'd8);
        checkResult(tag, expSum, expCout, expOvf);
        out_ready = 1'b1;
        nextCycle();
        out_ready = 1'b0;
        checkOutput({tag, "_release_valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_release_ready"}, 64'(in_ready), 64'd1);
        checkOutput({tag, "_held_sum"}, 64'(sum), 64'(expSum));
    endtask

    initial begin
        int cycles;
        int busyCycles;

        rst_n = 1'b0;
        repeat (3) nextCycle();
        checkReset("reset");
        rst_n = 1'b1;
        nextCycle();

        applyStimulus("zero",    8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus("ff_p_1",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus("7f_p_1",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        applyStimulus("a5_p_5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);

        // Backpressure with a second operand waiting, then back-to-back accept.
        a = 8'h12;
        b = 8'h34;
        cin = 1'b0;
        in_valid = 1'b1;
        nextCycle();
        a = 8'h3C;
        b = 8'hC3;
        waitResult("bp_first", cycles, busyCycles);
        checkOutput("bp_first_latency", 64'(cycles), 64'd8);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_hold_sum",   64'(sum),       64'h46);
            checkOutput("bp_hold_ready", 64'(in_ready),  64'd0);
            checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
            nextCycle();
        end
        checkResult("bp_first", 8'h46, 1'b0, 1'b0);
        out_ready = 1'b1;
        #1;
        checkOutput("bp_accept_ready", 64'(in_ready), 64'd1);
        nextCycle();
        out_ready = 1'b0;
        in_valid = 1'b0;
        checkOutput("bp_second_valid", 64'(out_valid), 64'd0);
        checkOutput("bp_second_busy",  64'(busy),      64'd1);
        waitResult("bp_second", cycles, busyCycles);
        checkOutput("bp_second_latency", 64'(cycles), 64'd8);
        checkResult("bp_second", 8'hFF, 1'b0, 1'b0);
        out_ready = 1'b1;
        nextCycle();
        out_ready = 1'b0;

        // Reset during the fourth RUN cycle discards the partial result.
        a = 8'h55;
        b = 8'h55;
        cin = 1'b0;
        in_valid = 1'b1;
        nextCycle();
        in_valid = 1'b0;
        repeat (3) nextCycle();
        checkOutput("midrst_running", 64'(busy), 64'd1);
        rst_n = 1'b0;
        nextCycle();
        checkReset("midrst");
        rst_n = 1'b1;
        nextCycle();
        checkOutput("midrst_no_result", 64'(out_valid), 64'd0);

        applyStimulus("after_rst", 8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial N-bit adder controller that time-shares one instance of the team's 1-bit full_adder cell over WIDTH clock cycles.
- Accepts operands through a valid/ready input handshake and shifts them LSB-first through the full adder, with a registered carry between bits.
- Presents sum, carry-out and signed overflow through a valid/ready output handshake.
- Sits between operand-producing logic and any consumer that can trade latency for area.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), width of the bit counter; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  addend A, captured on the input handshake.
- b  input  WIDTH  addend B, captured on the input handshake.
- cin  input  1  carry-in, captured on the input handshake.
- out_valid  output  1  result is valid and held.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  A+B+cin modulo 2^WIDTH.
- cout  output  1  carry out of the MSB.
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- busy  output  1  high while in RUN.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state goes to IDLE.
  - in_ready=1 from the following cycle.
  - out_valid, busy, sum, cout, ovf all go to 0.
  - Shift registers, carry register and counter are cleared.
  - Reset has priority over every other event, including mid-RUN; a partial result is discarded and never reported.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture a→a_sh, b→b_sh, cin→carry; clear sum_sh and cnt; go to RUN.
- RUN (WIDTH cycles, busy=1, in_ready=0):
  - Each cycle the full_adder sees a_sh[0], b_sh[0], carry.
  - a_sh and b_sh shift right by one.
  - sum_sh shifts right with the adder sum bit entering at the MSB.
  - carry <= adder carry-out.
  - cnt increments.
  - On the cycle with cnt==WIDTH-1:
    - Latch the adder's carry-in (the carry into the MSB) for ovf.
    - Load sum, cout, and ovf = carry_into_msb XOR cout.
    - Set out_valid=1; go to DONE.
- Latency: out_valid rises exactly WIDTH cycles after the input-handshake edge.
- DONE:
  - out_valid=1; sum, cout, ovf held stable while out_ready=0.
  - in_ready = out_ready, combinational from out_ready and state only.
  - On out_ready=1 with in_valid=0: out_valid=0; go to IDLE.
  - On out_ready=1 with in_valid=1: new operands are captured in the same cycle; go directly to RUN (no bubble); out_valid=0.
- Outputs sum, cout and ovf keep their last value after the result handshake until the next result is loaded; consumers qualify them with out_valid.
- in_valid while in RUN is ignored (in_ready=0). The upstream must hold its operands until the handshake.
- cnt runs 0..WIDTH-1 and never wraps inside RUN. It is reset to 0 on every capture.
- Arithmetic: unsigned modulo 2^WIDTH. cout is the (WIDTH+1)th bit. ovf is meaningful for signed interpretation only.

Decomposition:
- Package serial_adder_pkg holds:
  - state enum/localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - localparam for maximum WIDTH.
- Sub-module: existing full_adder (ports a, b, cin, sout, cout), instantiated exactly once. No other sub-modules; the FSM, shift registers and counter stay in serial_adder_ctrl.

Test Plan (WIDTH=8):
- Reset then a=8'h00, b=8'h00, cin=0 → out_valid exactly 8 cycles after the handshake; sum=8'h00, cout=0, ovf=0; busy high for 8 cycles.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1, ovf=0.
- a=8'h7F, b=8'h01, cin=0 → sum=8'h80, cout=0, ovf=1.
- a=8'hA5, b=8'h5A, cin=1 → sum=8'h00, cout=1, ovf=0.
- Backpressure and back-to-back:
  - Stimulus: first op a=8'h12, b=8'h34, cin=0; hold out_ready=0 for 5 cycles in DONE while in_valid=1 with a=8'h3C, b=8'hC3, cin=0.
  - While out_ready=0: sum=8'h46 stays stable and in_ready=0.
  - On out_ready=1: the second op is accepted in the same cycle; 8 cycles later sum=8'hFF, cout=0, ovf=0.
- Reset mid-op: assert rst_n=0 on the 4th RUN cycle → next cycle out_valid=0, busy=0, in_ready=1, sum=0. A subsequent op a=8'h01, b=8'h01, cin=1 gives sum=8'h03.
